// File: rtl/alu.sv
// 32-bit MIPS-style ALU with registered Result/Zero/Overflow (one cycle latency).
// Synchronous active-high reset returns Result=0, Zero=1, Overflow=0.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUctr,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);

  localparam int unsigned SA_W  = 5;
  localparam int unsigned LUI_W = 16;
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [3:0] OP_NOR   = 4'b0000;
  localparam logic [3:0] OP_ADDU  = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SUBU  = 4'b0101;
  localparam logic [3:0] OP_LUI   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1011;
  localparam logic [3:0] OP_PASSA = 4'b1100;
  localparam logic [3:0] OP_SLTU  = 4'b1101;
  localparam logic [3:0] OP_ADD   = 4'b1110;
  localparam logic [3:0] OP_PASSB = 4'b1111;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SA_W-1:0]  sa;
  logic             add_ovf;
  logic             sub_ovf;

  // Shared adder/subtractor and signed-overflow detection.
  always_comb begin
    sum     = A + B;
    diff    = A - B;
    sa      = A[SA_W-1:0];
    add_ovf = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
    sub_ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
  end

  // Operation select; Zero is derived from the same next result.
  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    case (ALUctr)
      OP_NOR:   result_d = ~(A | B);
      OP_ADDU:  result_d = sum;
      OP_AND:   result_d = A & B;
      OP_OR:    result_d = A | B;
      OP_SUB: begin
        result_d   = diff;
        overflow_d = sub_ovf;
      end
      OP_SUBU:  result_d = diff;
      OP_LUI:   result_d = {B[LUI_W-1:0], LUI_W'(0)};
      OP_XOR:   result_d = A ^ B;
      OP_SRL:   result_d = B >> sa;
      OP_SRA:   result_d = WIDTH'($signed(B) >>> sa);
      OP_SLL:   result_d = B << sa;
      OP_SLT:   result_d = WIDTH'($signed(A) < $signed(B));
      OP_PASSA: result_d = A;
      OP_SLTU:  result_d = WIDTH'(A < B);
      OP_ADD: begin
        result_d   = sum;
        overflow_d = add_ovf;
      end
      OP_PASSB: result_d = B;
      default:  result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: expected results are queued when an operation
// is driven and popped when the registered outputs appear one cycle later.
module tb_alu;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        o;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] A, B;
  logic [3:0]  ALUctr;
  logic [31:0] Result;
  logic        Zero, Overflow;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t sb[$];

  alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUctr(ALUctr),
    .Result(Result), .Zero(Zero), .Overflow(Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference model, written differently from the RTL.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    vec_t   v;
    longint s;
    logic [63:0] ext;
    int     sh;
    sh = int'(a[4:0]);
    v.op = op; v.a = a; v.b = b; v.o = 1'b0; v.r = 32'h0;
    case (op)
      4'h0: v.r = ~a & ~b;
      4'h1: v.r = 32'(longint'(a) + longint'(b));
      4'h2: v.r = a & b;
      4'h3: v.r = a | b;
      4'h4: begin
        s = longint'($signed(a)) - longint'($signed(b));
        v.r = 32'(s);
        v.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h5: v.r = a + ~b + 32'd1;
      4'h6: v.r = b * 32'h10000;
      4'h7: v.r = (a | b) & ~(a & b);
      4'h8: v.r = 32'(64'(b) >> sh);
      4'h9: begin
        ext = {{32{b[31]}}, b} >> sh;
        v.r = ext[31:0];
      end
      4'hA: v.r = 32'(64'(b) << sh);
      4'hB: v.r = {31'h0, (longint'($signed(a)) < longint'($signed(b)))};
      4'hC: v.r = a;
      4'hD: v.r = {31'h0, (longint'(a) < longint'(b))};
      4'hE: begin
        s = longint'($signed(a)) + longint'($signed(b));
        v.r = 32'(s);
        v.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: v.r = b;
    endcase
    v.z = (v.r == 32'h0);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; A = 32'h0; B = 32'h0; ALUctr = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (Result !== 32'h0 || Zero !== 1'b1 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got r=%h z=%b o=%b exp r=00000000 z=1 o=0",
               Result, Zero, Overflow);
    end
    @(negedge clk);
    A = 32'h34; B = 32'h12; ALUctr = 4'b1110;
    @(posedge clk);
    #1;
    n_checks++;
    if (Result !== 32'h0 || Zero !== 1'b1 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority got r=%h z=%b o=%b exp r=00000000 z=1 o=0",
               Result, Zero, Overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith_logic();
    vec_t v[8];
    vec_t e;
    v[0] = '{4'hE, 32'h34, 32'h12, 32'h46, 1'b0, 1'b0};
    v[1] = '{4'h4, 32'h34, 32'h12, 32'h22, 1'b0, 1'b0};
    v[2] = '{4'h1, 32'h1,  32'h1,  32'h2,  1'b0, 1'b0};
    v[3] = '{4'h1, 32'h2,  32'h2,  32'h4,  1'b0, 1'b0};
    v[4] = '{4'h2, 32'h34, 32'h12, 32'h10, 1'b0, 1'b0};
    v[5] = '{4'h3, 32'h34, 32'h12, 32'h36, 1'b0, 1'b0};
    v[6] = '{4'h7, 32'h34, 32'h12, 32'h26, 1'b0, 1'b0};
    v[7] = '{4'h0, 32'h34, 32'h12, 32'hFFFFFFC9, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ALUctr = v[i].op; A = v[i].a; B = v[i].b;
      sb.push_back(v[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (Result !== e.r || Zero !== e.z || Overflow !== e.o) begin
        n_fail++;
        $display("FAIL arith_logic[%0d] op=%b got r=%h z=%b o=%b exp r=%h z=%b o=%b",
                 i, e.op, Result, Zero, Overflow, e.r, e.z, e.o);
      end
    end
  endtask

  task automatic test_shift_misc();
    vec_t v[10];
    vec_t e;
    v[0] = '{4'hA, 32'h3,  32'hFFFFFFFF, 32'hFFFFFFF8, 1'b0, 1'b0};
    v[1] = '{4'h8, 32'h3,  32'hFFFFFFFF, 32'h1FFFFFFF, 1'b0, 1'b0};
    v[2] = '{4'h9, 32'h3,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
    v[3] = '{4'h9, 32'h23, 32'h80000000, 32'hF0000000, 1'b0, 1'b0};
    v[4] = '{4'h5, 32'h34, 32'h34,       32'h0,        1'b1, 1'b0};
    v[5] = '{4'h6, 32'hFFFF, 32'hAAAA,   32'hAAAA0000, 1'b0, 1'b0};
    v[6] = '{4'hB, 32'hFFFFFFFF, 32'h1,  32'h1,        1'b0, 1'b0};
    v[7] = '{4'hD, 32'hFFFFFFFF, 32'h1,  32'h0,        1'b1, 1'b0};
    v[8] = '{4'hC, 32'h00400020, 32'h5,  32'h00400020, 1'b0, 1'b0};
    v[9] = '{4'h8, 32'hFFFFFFE0, 32'h1234ABCD, 32'h1234ABCD, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ALUctr = v[i].op; A = v[i].a; B = v[i].b;
      sb.push_back(v[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (Result !== e.r || Zero !== e.z || Overflow !== e.o) begin
        n_fail++;
        $display("FAIL shift_misc[%0d] op=%b got r=%h z=%b o=%b exp r=%h z=%b o=%b",
                 i, e.op, Result, Zero, Overflow, e.r, e.z, e.o);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[5];
    vec_t e;
    v[0] = '{4'hE, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1};
    v[1] = '{4'h4, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1};
    v[2] = '{4'h1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0};
    v[3] = '{4'hE, 32'h80000000, 32'h80000000, 32'h0, 1'b1, 1'b1};
    v[4] = '{4'h5, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ALUctr = v[i].op; A = v[i].a; B = v[i].b;
      sb.push_back(v[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (Result !== e.r || Zero !== e.z || Overflow !== e.o) begin
        n_fail++;
        $display("FAIL overflow[%0d] op=%b got r=%h z=%b o=%b exp r=%h z=%b o=%b",
                 i, e.op, Result, Zero, Overflow, e.r, e.z, e.o);
      end
    end
  endtask

  // Random op every cycle; each result must show up exactly one edge later.
  task automatic test_back_to_back();
    vec_t e;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = $urandom();
      if (i % 8 == 0) b = a;
      if (i % 8 == 1) a = 32'h7FFFFFF0;
      ALUctr = op; A = a; B = b;
      sb.push_back(model(op, a, b));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL back_to_back[%0d] scoreboard empty got r=%h", i, Result);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (Result !== e.r || Zero !== e.z || Overflow !== e.o) begin
          n_fail++;
          $display("FAIL back_to_back[%0d] op=%b a=%h b=%h got r=%h z=%b o=%b exp r=%h z=%b o=%b",
                   i, e.op, e.a, e.b, Result, Zero, Overflow, e.r, e.z, e.o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith_logic();
    test_shift_misc();
    test_overflow();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d leftover exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit MIPS-style arithmetic/logic unit for the single-cycle CPU datapath; executes the operation selected by the 4-bit ALUctr from the control unit.
- Computes Result, Zero (branch compare) and signed Overflow.
- Outputs are registered: one clock of latency from operands/control to outputs.

Parameters:
- WIDTH, 32, datapath width. Shift amount is always the low 5 bits of A. The LUI shift is fixed at 16.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- A  input  32  operand A; also the shift amount source (A[4:0]) for shifts
- B  input  32  operand B; the value shifted by shift ops; immediate source for LUI
- ALUctr  input  4  operation select
- Result  output  32  registered operation result
- Zero  output  1  registered; 1 when the registered Result == 0
- Overflow  output  1  registered; signed overflow flag for ADD/SUB only

Behaviour:
- Reset (rst=1 at rising edge): Result=0, Zero=1 (consistent with Result=0), Overflow=0. Reset has priority over any operation in the same cycle.
- Otherwise, each rising edge registers f(A,B,ALUctr). Inputs are sampled at the edge, and the outputs hold until the next edge.
- Latency is exactly 1 cycle. There is no handshake; a new operation can be issued every cycle.
- ALUctr encoding (sa = A[4:0]):
  - 0000 NOR: ~(A|B)
  - 0001 ADDU: A+B mod 2^32; Overflow=0 (lw/sw address)
  - 0010 AND: A&B
  - 0011 OR: A|B
  - 0100 SUB: A-B, signed; Overflow checked
  - 0101 SUBU: A-B mod 2^32; Overflow=0 (beq compare via Zero)
  - 0110 LUI: {B[15:0], 16'h0000}
  - 0111 XOR: A^B
  - 1000 SRL: B >> sa, zero fill
  - 1001 SRA: B >>> sa, sign fill from B[31]
  - 1010 SLL: B << sa, zero fill
  - 1011 SLT: 1 if $signed(A) < $signed(B), else 0
  - 1100 PASSA: A (jr target pass-through)
  - 1101 SLTU: 1 if A < B unsigned, else 0
  - 1110 ADD: A+B, signed; Overflow checked
  - 1111 PASSB: B
- Overflow rules:
  - ADD: set when A[31]==B[31] and Result[31]!=A[31].
  - SUB: set when A[31]!=B[31] and Result[31]!=A[31].
  - All other ops: 0.
  - On overflow, the wrapped 32-bit result is still registered; no trap.
- Zero is computed from the new result in the same cycle, for every op including PASSA/PASSB/SLT.
- Shifts use only A[4:0]; A[31:5] is ignored. A shift of 0 returns B unchanged.
- X/Z on inputs propagates as simulator X; no X-masking required.
- Fully synchronous single clock domain. No combinational path from inputs to outputs.

Test Plan:
- Reset: rst=1 for 2 cycles -> Result=0, Zero=1, Overflow=0. Then apply ADD with A=0x34, B=0x12 while rst=1 -> outputs stay at reset values.
- Arithmetic, A=0x34, B=0x12 (each result one cycle after the inputs):
  - ADD (1110) -> 0x46
  - SUB (0100) -> 0x22
  - ADDU (0001) with A=B=1 -> 0x2; with A=B=2 -> 0x4
  - Zero=0 and Overflow=0 throughout.
- Logic, A=0x34, B=0x12: AND -> 0x10, OR -> 0x36, XOR -> 0x26, NOR -> 0xFFFFFFC9.
- Shifts, A=3, B=0xFFFFFFFF: SLL -> 0xFFFFFFF8, SRL -> 0x1FFFFFFF, SRA -> 0xFFFFFFFF. Also A=0x23 (sa=3), B=0x80000000: SRA -> 0xF0000000.
- Compare/misc:
  - SUBU with A=B=0x34 -> Result=0, Zero=1.
  - LUI with A=0xFFFF, B=0xAAAA -> 0xAAAA0000.
  - SLT with A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
  - PASSA with A=0x00400020 -> 0x00400020.
- Overflow:
  - ADD 0x7FFFFFFF+1 -> Result=0x80000000, Overflow=1.
  - SUB 0x80000000-1 -> Result=0x7FFFFFFF, Overflow=1.
  - ADDU 0x7FFFFFFF+1 -> Overflow=0.
  - Back-to-back ops on consecutive cycles each appear exactly one cycle later.
